// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle for seg7_scan_driver: BCD digit inputs in, multiplexed display drive out.
interface seg7_scan_driver_if;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [3:0] status;
    logic       status_en;
    logic       blink_en;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    modport master (
        output hundreds, tens, ones, status, status_en, blink_en,
        input  seg, dp, an, frame_tick
    );

    modport slave (
        input  hundreds, tens, ones, status, status_en, blink_en,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit seven-segment driver with frame-synchronous latching,
// leading-zero blanking, invalid-BCD dash and whole-display blink.
module seg7_scan_driver #(
    parameter int unsigned CLK_HZ       = 100_000_000,
    parameter int unsigned REFRESH_HZ   = 1000,
    parameter int unsigned BLINK_FRAMES = 125,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input logic              clk,
    input logic              reset,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned Div  = CLK_HZ / REFRESH_HZ;
    localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
    localparam int unsigned BfW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic        Inv  = (ACTIVE_LOW != 0);

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    logic [CntW-1:0] cnt_q;
    logic [1:0]      idx_q;
    logic [3:0]      sh_hun_q, sh_ten_q, sh_one_q, sh_sta_q;
    logic            sh_sta_en_q, sh_blink_q;
    logic [BfW-1:0]  pcnt_q;
    logic            phase_q;
    logic            blank_q;
    logic [6:0]      seg_q;
    logic [3:0]      an_q;
    logic            tick_q;

    logic            slot_edge, wrap;
    logic [1:0]      idx_d;
    logic [3:0]      hun_d, ten_d, one_d, sta_d;
    logic            sta_en_d, blank_d;
    logic [3:0]      digit;
    logic            vis;
    logic [6:0]      seg_on;
    logic [3:0]      an_on;

    always_comb begin
        slot_edge = (cnt_q == CntW'(Div - 1));
        wrap      = slot_edge && (idx_q == 2'd3);
        idx_d     = idx_q + 2'd1;
        hun_d     = wrap ? bus.hundreds  : sh_hun_q;
        ten_d     = wrap ? bus.tens      : sh_ten_q;
        one_d     = wrap ? bus.ones      : sh_one_q;
        sta_d     = wrap ? bus.status    : sh_sta_q;
        sta_en_d  = wrap ? bus.status_en : sh_sta_en_q;
        // Blink decision is frozen per frame, using the phase in force before this wrap.
        blank_d   = wrap ? (bus.blink_en & phase_q) : blank_q;

        digit = one_d;
        vis   = 1'b1;
        unique case (idx_d)
            2'd0: begin digit = one_d; vis = 1'b1;                              end
            2'd1: begin digit = ten_d; vis = !(hun_d == 4'd0 && ten_d == 4'd0); end
            2'd2: begin digit = hun_d; vis = (hun_d != 4'd0);                   end
            2'd3: begin digit = sta_d; vis = sta_en_d;                          end
        endcase
        seg_on = vis ? decode(digit) : 7'b0;
        an_on  = (vis && !blank_d) ? (4'b0001 << idx_d) : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            idx_q       <= 2'd3;
            sh_hun_q    <= '0;
            sh_ten_q    <= '0;
            sh_one_q    <= '0;
            sh_sta_q    <= '0;
            sh_sta_en_q <= 1'b0;
            sh_blink_q  <= 1'b0;
            pcnt_q      <= '0;
            phase_q     <= 1'b0;
            blank_q     <= 1'b0;
            seg_q       <= {7{Inv}};
            an_q        <= {4{Inv}};
            tick_q      <= 1'b0;
        end else begin
            tick_q <= wrap;
            if (slot_edge) begin
                cnt_q <= '0;
                idx_q <= idx_d;
                seg_q <= seg_on ^ {7{Inv}};
                an_q  <= an_on ^ {4{Inv}};
            end else begin
                cnt_q <= cnt_q + CntW'(1);
            end
            if (wrap) begin
                sh_hun_q    <= hun_d;
                sh_ten_q    <= ten_d;
                sh_one_q    <= one_d;
                sh_sta_q    <= sta_d;
                sh_sta_en_q <= sta_en_d;
                sh_blink_q  <= bus.blink_en;
                blank_q     <= blank_d;
                if (pcnt_q == BfW'(BLINK_FRAMES - 1)) begin
                    pcnt_q  <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    pcnt_q <= pcnt_q + BfW'(1);
                end
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.an         = an_q;
    assign bus.dp         = Inv;
    assign bus.frame_tick = tick_q;
endmodule
